// File: rtl/sbox_ctrl.sv
// S-box table loader and shared lookup-port arbiter for sbox_lut.
// Streams config words into a shadow table, commits it, then serves ke/sb lookups.
module sbox_ctrl #(
  parameter int NUM_WORDS = 64,
  parameter int ARB_MODE  = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_wr_vld,
  input  logic [31:0]   cfg_wr_data,
  output logic          cfg_done,
  output logic          cfg_err,
  output logic [2047:0] sbox_in,
  output logic          sbox_in_vld,
  input  logic          sbox_available,
  output logic [31:0]   lut_val,
  output logic          lut_val_vld,
  input  logic [31:0]   lut_data,
  input  logic          ke_req,
  input  logic [31:0]   ke_val,
  output logic          ke_gnt,
  output logic          ke_rsp_vld,
  output logic [31:0]   ke_rsp_data,
  input  logic          sb_req,
  input  logic [31:0]   sb_val,
  output logic          sb_gnt,
  output logic          sb_rsp_vld,
  output logic [31:0]   sb_rsp_data,
  output logic [2:0]    state_dbg
);

  localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_EMPTY      = 3'd0,
    S_LOAD       = 3'd1,
    S_COMMIT     = 3'd2,
    S_WAIT_AVAIL = 3'd3,
    S_READY      = 3'd4
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2047:0]   shadow;
  logic            rr_ke;
  logic            gnt_ok;
  logic            ke_win;
  logic            wr_en;
  logic [CW-1:0]   wr_idx;

  assign sbox_in   = shadow;
  assign state_dbg = state;

  // Lookups only while the committed table is live and no reload begins this cycle.
  always_comb begin
    gnt_ok = (state == S_READY) && !cfg_wr_vld;
    if (ARB_MODE != 0) ke_win = ke_req;
    else               ke_win = ke_req && (!sb_req || rr_ke);
    ke_gnt      = gnt_ok && ke_win;
    sb_gnt      = gnt_ok && sb_req && !ke_win;
    lut_val_vld = ke_gnt || sb_gnt;
    lut_val     = ke_gnt ? ke_val : (sb_gnt ? sb_val : 32'd0);
    wr_en       = cfg_wr_vld && (state == S_EMPTY || state == S_LOAD || state == S_READY);
    wr_idx      = (state == S_LOAD) ? cnt : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_EMPTY;
      cnt         <= '0;
      shadow      <= '0;
      rr_ke       <= 1'b1;
      cfg_done    <= 1'b0;
      cfg_err     <= 1'b0;
      sbox_in_vld <= 1'b0;
      ke_rsp_vld  <= 1'b0;
      ke_rsp_data <= 32'd0;
      sb_rsp_vld  <= 1'b0;
      sb_rsp_data <= 32'd0;
    end else begin
      sbox_in_vld <= 1'b0;
      cfg_err     <= 1'b0;
      ke_rsp_vld  <= ke_gnt;
      sb_rsp_vld  <= sb_gnt;
      if (ke_gnt) ke_rsp_data <= lut_data;
      if (sb_gnt) sb_rsp_data <= lut_data;
      if (ke_gnt)      rr_ke <= 1'b0;
      else if (sb_gnt) rr_ke <= 1'b1;

      if (wr_en) begin
        for (int k = 0; k < NUM_WORDS; k++) begin
          if (wr_idx == CW'(k)) shadow[k*32 +: 32] <= cfg_wr_data;
        end
      end

      case (state)
        S_EMPTY: begin
          if (cfg_wr_vld) begin
            cnt   <= CW'(1);
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (cfg_wr_vld) begin
            if (cnt == LAST) begin
              cnt         <= '0;
              sbox_in_vld <= 1'b1;
              state       <= S_COMMIT;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_COMMIT: begin
          if (cfg_wr_vld) cfg_err <= 1'b1;
          state <= S_WAIT_AVAIL;
        end
        S_WAIT_AVAIL: begin
          if (cfg_wr_vld) cfg_err <= 1'b1;
          if (sbox_available) begin
            cfg_done <= 1'b1;
            state    <= S_READY;
          end
        end
        S_READY: begin
          if (cfg_wr_vld) begin
            cfg_done <= 1'b0;
            cnt      <= CW'(1);
            state    <= S_LOAD;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: doc/sbox_ctrl.md
Name: sbox_ctrl

Overview:
- Controller that loads the 256-byte S-box table into sbox_lut and shares its single lookup port between the key-expansion and sub-bytes requesters.
- Collects the table as a stream of 32-bit config words into a shadow register, then commits it with a one-cycle sbox_in_vld pulse.
- Holds off all lookups until sbox_lut confirms with sbox_available, then arbitrates requests and returns registered lookup results.

Parameters:
- NUM_WORDS, 64, config words per table load (256 bytes / 4).
- ARB_MODE, 0, 0 = round-robin; 1 = fixed priority with key-expansion highest.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-low
- cfg_wr_vld  in  1  config word valid
- cfg_wr_data  in  32  config word; word k bits [8j+7:8j] = S-box byte 4k+j
- cfg_done  out  1  table loaded and acknowledged; lookups enabled
- cfg_err  out  1  one-cycle pulse when a config word is dropped
- sbox_in  out  2048  shadow table; byte n at bits [8n+7:8n], n = row*16+col
- sbox_in_vld  out  1  one-cycle commit strobe to sbox_lut
- sbox_available  in  1  commit acknowledge from sbox_lut
- lut_val  out  32  lookup address word to sbox_lut
- lut_val_vld  out  1  lookup valid to sbox_lut
- lut_data  in  32  combinational lookup result from sbox_lut
- ke_req  in  1  key-expansion request; held until granted
- ke_val  in  32  key-expansion word to substitute
- ke_gnt  out  1  key-expansion grant (combinational)
- ke_rsp_vld  out  1  key-expansion result valid
- ke_rsp_data  out  32  key-expansion result
- sb_req  in  1  sub-bytes request; held until granted
- sb_val  in  32  sub-bytes word to substitute
- sb_gnt  out  1  sub-bytes grant (combinational)
- sb_rsp_vld  out  1  sub-bytes result valid
- sb_rsp_data  out  32  sub-bytes result

Behaviour:
- Reset (reset low, asynchronous) takes effect immediately, including mid-load or mid-lookup:
  - all outputs 0; shadow table 0; word counter 0; state EMPTY; round-robin pointer set to key-expansion; cfg_done 0.
- FSM states: EMPTY, LOAD, COMMIT, WAIT_AVAIL, READY.
  - EMPTY: first cfg_wr_vld writes word 0, counter becomes 1, go to LOAD.
  - LOAD: each cfg_wr_vld writes word[counter] and increments the counter. The word written at counter NUM_WORDS-1 moves to COMMIT. No gaps are required between words.
  - COMMIT: sbox_in_vld = 1 for exactly one cycle, then go to WAIT_AVAIL.
  - WAIT_AVAIL: stay until sbox_available = 1, then set cfg_done = 1 and go to READY. No timeout.
  - READY: cfg_wr_vld starts a reload. cfg_done clears the same cycle, that word is written as word 0, counter becomes 1, go to LOAD. No grant is issued in that cycle.
- cfg_wr_vld in COMMIT or WAIT_AVAIL: word dropped, cfg_err pulses the following cycle, shadow table unchanged.
- sbox_in is driven continuously from the shadow table. It is only meaningful to sbox_lut at sbox_in_vld.
- Grants are issued only in READY with no cfg_wr_vld that cycle. At most one grant per cycle.
  - Single requester: it is granted.
  - Both requesting, ARB_MODE 0: grant the pointer side. After a grant the pointer moves to the other side, so alternate grants under continuous contention.
  - Both requesting, ARB_MODE 1: ke always wins. sb may starve; this is accepted.
- Lookup, grant cycle N:
  - lut_val_vld = 1 and lut_val = the granted requester's value.
  - Cycle N+1: the granted requester's rsp_vld = 1 and rsp_data = lut_data registered from cycle N. Fixed latency of 1.
  - Otherwise lut_val_vld = 0, lut_val = 0, and rsp_vld = 0 with rsp_data holding its last value.
- Throughput is one lookup per cycle. Back-to-back grants to the same requester are allowed when it is alone.
- A requester deasserting req before it is granted is legal; no grant is issued to it.
- A response already in flight at a reload still completes in the next cycle.

Test Plan:
- Reset then 64 words carrying the AES S-box -> sbox_in_vld single pulse 1 cycle after the 64th word; sbox_in[7:0] = 8'h63, sbox_in[2047:2040] = 8'h16; cfg_done rises the cycle after sbox_available.
- READY, ke_req with ke_val = 32'h00010203 -> ke_gnt same cycle; ke_rsp_vld next cycle with ke_rsp_data = 32'h637c777b.
- ARB_MODE 0, ke_req and sb_req held for 4 cycles -> grants ke, sb, ke, sb; each rsp_vld exactly one cycle after its grant; ARB_MODE 1 gives ke all 4.
- Request before load completes (state LOAD or WAIT_AVAIL) -> no grant, lut_val_vld = 0 until cfg_done = 1; first grant in the cycle cfg_done is 1.
- cfg_wr_vld during WAIT_AVAIL -> cfg_err pulse, shadow table unchanged; cfg_wr_vld in READY -> cfg_done = 0, reload from word 0, no grants until new sbox_available.
- reset asserted after 30 words -> counter 0, sbox_in = 0, state EMPTY; full 64-word reload then completes normally.
